// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_pkg
//  Description : Shared types and constants for the JTAG TAP controller:
//                TAP state encoding, instruction opcodes, decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    localparam int IR_WIDTH = 2;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST  = 2'b00;
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = 2'b01;
    localparam logic [IR_WIDTH-1:0] OP_BYPASS  = 2'b11;
    // Fixed pattern loaded into the IR shift register in Capture-IR
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 2'b01;

    // Standard 1149.1 state encoding
    typedef enum logic [3:0] {
        EXIT2_DR = 4'h0,
        EXIT1_DR = 4'h1,
        SHIFT_DR = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EXIT2_IR = 4'h8,
        EXIT1_IR = 4'h9,
        SHIFT_IR = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_t;

    // EXTEST and SAMPLE select the boundary chain; everything else (including
    // the undefined 2'b10) falls through to bypass.
    function automatic logic is_boundary(input logic [IR_WIDTH-1:0] ir);
        return (ir == OP_EXTEST) || (ir == OP_SAMPLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_ctrl_if
//  Description : TAP pins plus control bundle between the TAP controller
//                (master) and the boundary-scan chip / tester (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface jtag_tap_ctrl_if;
    import jtag_pkg::*;

    logic                tms;
    logic                tdi;
    logic                dr_tdo;
    logic                shift_dr;
    logic                up_enable;
    logic                mode;
    logic                bp_shift;
    logic                sel;
    logic                tdo;
    logic                tdo_en;
    logic [IR_WIDTH-1:0] ir;

    modport master (
        input  tms, tdi, dr_tdo,
        output shift_dr, up_enable, mode, bp_shift, sel, tdo, tdo_en, ir
    );

    modport slave (
        output tms, tdi, dr_tdo,
        input  shift_dr, up_enable, mode, bp_shift, sel, tdo, tdo_en, ir
    );

endinterface
`default_nettype wire

// File: rtl/tap_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tap_fsm
//  Description : 16-state IEEE 1149.1 TAP state machine driven by tms.
//                Exposes both the current and the next state.
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_fsm
    import jtag_pkg::*;
(
    input  wire logic       tck,
    input  wire logic       rst,
    input  wire logic       tms,
    output tap_state_t      state,
    output tap_state_t      state_nxt
);

    tap_state_t r_state;
    tap_state_t w_state_nxt;

    // State register; reset forces Test-Logic-Reset
    always_ff @(posedge tck) begin
        if (rst) begin
            r_state <= TLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state transitions on tms
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TLR:      w_state_nxt = tms ? TLR      : RTI;
            RTI:      w_state_nxt = tms ? SEL_DR   : RTI;
            SEL_DR:   w_state_nxt = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   w_state_nxt = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: w_state_nxt = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: w_state_nxt = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: w_state_nxt = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: w_state_nxt = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   w_state_nxt = tms ? SEL_DR   : RTI;
            SEL_IR:   w_state_nxt = tms ? TLR      : CAP_IR;
            CAP_IR:   w_state_nxt = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: w_state_nxt = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: w_state_nxt = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: w_state_nxt = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: w_state_nxt = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   w_state_nxt = tms ? SEL_DR   : RTI;
            default:  w_state_nxt = TLR;
        endcase
    end

    assign state     = r_state;
    assign state_nxt = w_state_nxt;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_ctrl
//  Description : TAP controller for one boundary-scan chip. Holds the
//                instruction register, decodes state + instruction into the
//                chip controls and muxes the top-level tdo.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl
    import jtag_pkg::*;
(
    input  wire logic      tck,
    input  wire logic      rst,
    jtag_tap_ctrl_if.master bus
);

    tap_state_t          w_state;
    tap_state_t          w_state_nxt;
    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] r_ir_sr;

    logic                w_boundary;
    logic                w_shift_dr;
    logic                w_up_enable;
    logic                w_mode;
    logic                w_bp_shift;
    logic                w_sel;
    logic                w_tdo;
    logic                w_tdo_en;

    tap_fsm u_tap_fsm (
        .tck       (tck),
        .rst       (rst),
        .tms       (bus.tms),
        .state     (w_state),
        .state_nxt (w_state_nxt)
    );

    // Instruction shift/update registers. Keyed on the next state for TLR so
    // ir already reads BYPASS in the first cycle the FSM sits in TLR.
    always_ff @(posedge tck) begin
        if (rst) begin
            r_ir    <= OP_BYPASS;
            r_ir_sr <= IR_CAPTURE;
        end else if (w_state_nxt == TLR) begin
            r_ir    <= OP_BYPASS;
            r_ir_sr <= IR_CAPTURE;
        end else begin
            case (w_state)
                CAP_IR:   r_ir_sr <= IR_CAPTURE;
                SHIFT_IR: r_ir_sr <= {bus.tdi, r_ir_sr[IR_WIDTH-1:1]};
                UPD_IR:   r_ir    <= r_ir_sr;
                default:  ;
            endcase
        end
    end

    // Zero-latency decode of registered state and instruction
    always_comb begin
        w_boundary  = is_boundary(r_ir);
        w_shift_dr  = (w_state == SHIFT_DR) &&  w_boundary;
        w_bp_shift  = (w_state == SHIFT_DR) && !w_boundary;
        w_up_enable = (w_state == UPD_DR)   &&  w_boundary;
        w_mode      = (r_ir == OP_EXTEST);
        w_sel       = !w_boundary;
        w_tdo       = 1'b0;
        w_tdo_en    = 1'b0;
        case (w_state)
            SHIFT_IR: begin
                w_tdo    = r_ir_sr[0];
                w_tdo_en = 1'b1;
            end
            SHIFT_DR: begin
                w_tdo    = bus.dr_tdo;
                w_tdo_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.shift_dr  = w_shift_dr;
    assign bus.up_enable = w_up_enable;
    assign bus.mode      = w_mode;
    assign bus.bp_shift  = w_bp_shift;
    assign bus.sel       = w_sel;
    assign bus.tdo       = w_tdo;
    assign bus.tdo_en    = w_tdo_en;
    assign bus.ir        = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_tap_ctrl
//  Description : Directed self-checking bench for jtag_tap_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    logic tck = 1'b0;
    logic rst;

    always #5 tck = ~tck;

    jtag_tap_ctrl_if bus ();

    jtag_tap_ctrl dut (
        .tck (tck),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply tms/tdi, clock once, settle just after the edge
    task automatic tick(input logic t, input logic d);
        bus.tms = t;
        bus.tdi = d;
        @(posedge tck);
        #1;
    endtask

    // From RTI: full IR scan of value v, ending back in RTI
    task automatic load_ir(input logic [1:0] v);
        tick(1'b1, 1'b0);               // SEL_DR
        tick(1'b1, 1'b0);               // SEL_IR
        tick(1'b0, 1'b0);               // CAP_IR
        tick(1'b0, 1'b0);               // SHIFT_IR, ir_sr = 01
        chk("ir_tdo_en", {7'd0, bus.tdo_en}, 8'd1);
        chk("ir_tdo_b0", {7'd0, bus.tdo}, 8'd1);
        tick(1'b0, v[0]);               // SHIFT_IR, ir_sr = {v0,0}
        chk("ir_tdo_b1", {7'd0, bus.tdo}, 8'd0);
        tick(1'b1, v[1]);               // EXIT1_IR
        tick(1'b1, 1'b0);               // UPD_IR
        tick(1'b0, 1'b0);               // RTI, ir updated
        chk("ir_value", {6'd0, bus.ir}, {6'd0, v});
    endtask

    // From RTI: n-bit DR scan; dr_tdo driven from pat, tdo checked per bit.
    // Counts enables over the whole visit including EXIT1/UPD/RTI.
    task automatic dr_scan(input int n, input logic [7:0] pat,
                           output int n_sh, output int n_bp, output int n_up);
        n_sh = 0; n_bp = 0; n_up = 0;
        tick(1'b1, 1'b0);               // SEL_DR
        tick(1'b0, 1'b0);               // CAP_DR
        n_up += int'(bus.up_enable);
        tick(1'b0, 1'b0);               // SHIFT_DR
        for (int i = 0; i < n; i++) begin
            bus.dr_tdo = pat[i];
            #1;
            chk("dr_tdo", {7'd0, bus.tdo}, {7'd0, pat[i]});
            n_sh += int'(bus.shift_dr);
            n_bp += int'(bus.bp_shift);
            n_up += int'(bus.up_enable);
            tick(i == n - 1, pat[i]);
        end
        for (int k = 0; k < 3; k++) begin  // EXIT1_DR, UPD_DR, RTI
            n_sh += int'(bus.shift_dr);
            n_bp += int'(bus.bp_shift);
            n_up += int'(bus.up_enable);
            tick(k == 0, 1'b0);
        end
        bus.dr_tdo = 1'b0;
    endtask

    int sh, bp, up;

    initial begin
        rst        = 1'b1;
        bus.tms    = 1'b1;
        bus.tdi    = 1'b0;
        bus.dr_tdo = 1'b0;
        repeat (2) @(posedge tck);
        #1;
        chk("rst_shift_dr", {7'd0, bus.shift_dr},  8'd0);
        chk("rst_up_en",    {7'd0, bus.up_enable}, 8'd0);
        chk("rst_mode",     {7'd0, bus.mode},      8'd0);
        chk("rst_bp_shift", {7'd0, bus.bp_shift},  8'd0);
        chk("rst_sel",      {7'd0, bus.sel},       8'd1);
        chk("rst_tdo",      {7'd0, bus.tdo},       8'd0);
        chk("rst_tdo_en",   {7'd0, bus.tdo_en},    8'd0);
        chk("rst_ir",       {6'd0, bus.ir},        8'h03);
        rst = 1'b0;
        tick(1'b0, 1'b0);               // RTI

        // Load EXTEST
        load_ir(OP_EXTEST);
        chk("extest_mode", {7'd0, bus.mode}, 8'd1);
        chk("extest_sel",  {7'd0, bus.sel},  8'd0);

        // Five tms=1 from RTI returns to TLR and restores BYPASS
        repeat (5) tick(1'b1, 1'b0);
        chk("tlr_ir",     {6'd0, bus.ir},     8'h03);
        chk("tlr_sel",    {7'd0, bus.sel},    8'd1);
        chk("tlr_mode",   {7'd0, bus.mode},   8'd0);
        chk("tlr_tdo_en", {7'd0, bus.tdo_en}, 8'd0);
        tick(1'b0, 1'b0);               // RTI

        // EXTEST 6-bit DR scan
        load_ir(OP_EXTEST);
        dr_scan(6, 8'b0010_1100, sh, bp, up);
        chk("ext_shift_cnt", 8'(sh), 8'd6);
        chk("ext_bp_cnt",    8'(bp), 8'd0);
        chk("ext_up_cnt",    8'(up), 8'd1);

        // Pause in the middle of a DR scan
        tick(1'b1, 1'b0);               // SEL_DR
        tick(1'b0, 1'b0);               // CAP_DR
        tick(1'b0, 1'b0);               // SHIFT_DR
        chk("p_shift_on",  {7'd0, bus.shift_dr}, 8'd1);
        tick(1'b1, 1'b0);               // EXIT1_DR
        tick(1'b0, 1'b0);               // PAUSE_DR
        chk("p_pause_sh",  {7'd0, bus.shift_dr},  8'd0);
        chk("p_pause_en",  {7'd0, bus.tdo_en},    8'd0);
        chk("p_pause_up",  {7'd0, bus.up_enable}, 8'd0);
        chk("p_pause_md",  {7'd0, bus.mode},      8'd1);
        tick(1'b1, 1'b0);               // EXIT2_DR
        tick(1'b0, 1'b0);               // SHIFT_DR
        chk("p_resume_sh", {7'd0, bus.shift_dr}, 8'd1);
        tick(1'b1, 1'b0);               // EXIT1_DR
        tick(1'b1, 1'b0);               // UPD_DR
        chk("p_upd",       {7'd0, bus.up_enable}, 8'd1);
        tick(1'b0, 1'b0);               // RTI
        chk("p_rti_up",    {7'd0, bus.up_enable}, 8'd0);

        // BYPASS 3-bit DR scan
        load_ir(OP_BYPASS);
        chk("byp_sel",  {7'd0, bus.sel},  8'd1);
        chk("byp_mode", {7'd0, bus.mode}, 8'd0);
        dr_scan(3, 8'b0000_0101, sh, bp, up);
        chk("byp_shift_cnt", 8'(sh), 8'd0);
        chk("byp_bp_cnt",    8'(bp), 8'd3);
        chk("byp_up_cnt",    8'(up), 8'd0);

        // Undefined opcode 2'b10 acts as BYPASS
        load_ir(2'b10);
        chk("u10_sel",  {7'd0, bus.sel},  8'd1);
        chk("u10_mode", {7'd0, bus.mode}, 8'd0);
        dr_scan(2, 8'b0000_0010, sh, bp, up);
        chk("u10_shift_cnt", 8'(sh), 8'd0);
        chk("u10_bp_cnt",    8'(bp), 8'd2);
        chk("u10_up_cnt",    8'(up), 8'd0);

        // SAMPLE: boundary selected, functional path
        load_ir(OP_SAMPLE);
        chk("smp_sel",  {7'd0, bus.sel},  8'd0);
        chk("smp_mode", {7'd0, bus.mode}, 8'd0);
        dr_scan(1, 8'b0000_0001, sh, bp, up);
        chk("smp_shift_cnt", 8'(sh), 8'd1);
        chk("smp_up_cnt",    8'(up), 8'd1);

        // Reset on the 3rd SHIFT_DR cycle of an EXTEST scan
        load_ir(OP_EXTEST);
        tick(1'b1, 1'b0);               // SEL_DR
        tick(1'b0, 1'b0);               // CAP_DR
        tick(1'b0, 1'b0);               // SHIFT_DR #1
        tick(1'b0, 1'b1);               // SHIFT_DR #2
        tick(1'b0, 1'b0);               // SHIFT_DR #3
        chk("rs_pre_shift", {7'd0, bus.shift_dr}, 8'd1);
        rst = 1'b1;
        tick(1'b1, 1'b0);               // tms=1 would go to EXIT1; rst wins
        rst = 1'b0;
        chk("rs_shift_dr", {7'd0, bus.shift_dr},  8'd0);
        chk("rs_bp_shift", {7'd0, bus.bp_shift},  8'd0);
        chk("rs_up_en",    {7'd0, bus.up_enable}, 8'd0);
        chk("rs_tdo_en",   {7'd0, bus.tdo_en},    8'd0);
        chk("rs_tdo",      {7'd0, bus.tdo},       8'd0);
        chk("rs_ir",       {6'd0, bus.ir},        8'h03);
        chk("rs_sel",      {7'd0, bus.sel},       8'd1);
        chk("rs_mode",     {7'd0, bus.mode},      8'd0);
        up = 0;
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0);
            up += int'(bus.up_enable);
        end
        chk("rs_no_up", 8'(up), 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1-style TAP controller that sequences one boundary-scan chip (six-cell boundary chain plus bypass register). Runs the 16-state TAP FSM from `tms`, holds a 2-bit instruction register and decodes state plus instruction into the chip's `shift_dr`, `up_enable`, `mode`, `bp_shift` and `sel` controls. Owns the top-level `tdo`, muxing the IR shift path against the chip's data-register `tdo`.

## Interface
- `IR_WIDTH`, 2: instruction register width.
- `OP_EXTEST`, 2'b00: boundary chain selected; cells drive outputs (`mode`=1).
- `OP_SAMPLE`, 2'b01: boundary chain selected; functional path (`mode`=0).
- `OP_BYPASS`, 2'b11: bypass register selected. 2'b10 is undefined and decodes as BYPASS.

- `tck` in 1: the single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tms` in 1: TAP mode select, sampled on rising `tck`.
- `tdi` in 1: serial in; feeds IR during Shift-IR (chip receives `tdi` directly).
- `dr_tdo` in 1: chip's serial out (boundary/bypass mux output).
- `shift_dr` out 1: boundary cells shift when 1, capture when 0.
- `up_enable` out 1: boundary update-latch enable.
- `mode` out 1: boundary output mux (1 = scan value drives pins).
- `bp_shift` out 1: bypass register shift enable.
- `sel` out 1: chip tdo mux; 0 = boundary chain, 1 = bypass.
- `tdo` out 1: serial out to next device/tester.
- `tdo_en` out 1: high in Shift-IR and Shift-DR.
- `ir` out IR_WIDTH: current (updated) instruction, for debug.

## Operation
- FSM states: TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR; transitions per 1149.1 on `tms` (e.g. TLR: tms=0→RTI; SEL_IR: tms=1→TLR).
- IR: shift register `ir_sr` plus update register `ir`. CAP_IR loads `ir_sr`=2'b01. SHIFT_IR shifts right, `tdi` into MSB. UPD_IR copies `ir_sr`→`ir`. In TLR, `ir`=OP_BYPASS.
- Decodes (combinational from registered state and `ir`):
  - `shift_dr` = (state==SHIFT_DR) && boundary instr.
  - `bp_shift` = (state==SHIFT_DR) && bypass instr.
  - `up_enable` = (state==UPD_DR) && boundary instr; one cycle per visit.
  - `mode` = (ir==OP_EXTEST); held through all states until `ir` changes.
  - `sel` = bypass instr.
- `tdo` = `ir_sr[0]` in SHIFT_IR; `dr_tdo` in SHIFT_DR; 0 otherwise.

## Timing
- Reset (`rst`=1 at a rising edge) or five consecutive `tms`=1 cycles from any state: state=TLR, `ir`=OP_BYPASS, `ir_sr`=2'b01. Outputs then: `shift_dr`=0, `up_enable`=0, `mode`=0, `bp_shift`=0, `sel`=1, `tdo`=0, `tdo_en`=0.
- `rst` has priority over `tms`; reset mid-SHIFT_DR/SHIFT_IR drops all enables the following cycle, discards `ir_sr` contents, never pulses `up_enable`.
- Outputs valid in the same cycle the state register enters the decoding state (zero-latency decode).
- N-bit DR scan: CAP_DR→SHIFT_DR held N cycles (`shift_dr`=1 for exactly N rising edges)→EXIT1_DR→UPD_DR: one `up_enable` cycle.
- PAUSE_DR/PAUSE_IR: enables low, chain contents frozen; resume via EXIT2→SHIFT.
- New `ir` takes effect on the cycle after UPD_IR; `mode`/`sel` change there, never mid-DR-scan.

## Structure
- Package `jtag_pkg`: 4-bit state enum (TLR=4'hF, standard 1149.1 encoding), `IR_WIDTH`, opcode constants, `is_boundary(ir)` function.
- Sub-module `tap_fsm`: state register and next-state logic only (`tck`, `rst`, `tms` → state). Top holds IR and output decode.

## Test plan
- From RTI, drive `tms`=1 for five cycles -> state TLR, `sel`=1, `mode`=0, `ir`=2'b11.
- IR scan loading 2'b00 (EXTEST) -> `tdo` shifts out 1 then 0 (captured 2'b01); after UPD_IR `ir`=2'b00, `mode`=1, `sel`=0.
- EXTEST DR scan of 6 bits, pattern 6'b101100 -> `shift_dr` high exactly 6 cycles, `tdo` mirrors `dr_tdo`, single `up_enable` pulse in UPD_DR.
- BYPASS DR scan, `tdi`=1,0,1 -> `bp_shift` high 3 cycles, `shift_dr`=0, `up_enable` never asserted.
- Load 2'b10 -> behaves as BYPASS (`sel`=1, `bp_shift` in SHIFT_DR).
- Assert `rst` on 3rd SHIFT_DR cycle -> next cycle TLR, all enables 0, no `up_enable`, `ir`=2'b11.
